// File: rtl/mmio_memory_unit.sv
// mmio_memory_unit: MEM-stage data memory with a memory-mapped I/O window.
// Word RAM occupies the low addresses. The top of the address space holds
// N_IN input ports, N_OUT output ports and one W1C STATUS register.
// Every read, whether it hits RAM or I/O, returns one cycle after the request
// edge together with a single-cycle rd_valid pulse.
//
// Request protocol: mem_read and mem_write are single-cycle requests sampled on
// every rising edge. There is no back-pressure; every request is accepted on the
// edge where it is seen. A read returns rd_data with rd_valid=1 exactly one cycle
// later. rd_data then holds until the next accepted read. If a read and a write
// target the same address on the same edge, the read returns the value from
// before the write.
module mmio_memory_unit #(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 10,
    parameter int          N_IN    = 2,
    parameter int          N_OUT   = 1,
    parameter int unsigned IO_BASE = 32'h3F0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    mem_write,
    input  logic                    mem_read,
    input  logic [N_IN*DATA_W-1:0]  in_data,
    input  logic [N_IN-1:0]         in_load,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic [N_OUT*DATA_W-1:0] out_port,
    output logic [N_OUT-1:0]        out_strobe
);

    // Word-granular map: RAM below IO_BASE, then inputs, outputs, STATUS.
    localparam int unsigned BASE_WORD   = IO_BASE / 4;
    localparam int unsigned RAM_DEPTH   = BASE_WORD;
    localparam int          RAM_AW      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int unsigned OUT_WORD    = BASE_WORD + N_IN;
    localparam int unsigned STATUS_WORD = BASE_WORD + N_IN + N_OUT;

    // Byte-lane bits are ignored; only whole words are addressed.
    logic unused_byte_lane;
    assign unused_byte_lane = ^addr[1:0];

    logic [ADDR_W-3:0] word_idx;
    int unsigned       word_num;
    logic [RAM_AW-1:0] ram_idx;

    assign word_idx = addr[ADDR_W-1:2];
    assign word_num = 32'(word_idx);
    assign ram_idx  = word_idx[RAM_AW-1:0];

    // Storage
    logic [DATA_W-1:0] ram    [RAM_DEPTH];
    logic [DATA_W-1:0] in_reg [N_IN];
    logic [N_IN-1:0]   pending;
    logic [N_IN-1:0]   overrun;

    // Address decode
    logic              sel_ram;
    logic [N_IN-1:0]   sel_in;
    logic [N_OUT-1:0]  sel_out;
    logic              sel_status;

    // Decode the word index into one-hot region selects; unmapped words select nothing.
    always_comb begin
        sel_ram    = (word_num < BASE_WORD);
        sel_in     = '0;
        sel_out    = '0;
        sel_status = (word_num == STATUS_WORD);
        for (int k = 0; k < N_IN; k++) begin
            if (word_num == BASE_WORD + 32'(k)) sel_in[k] = 1'b1;
        end
        for (int k = 0; k < N_OUT; k++) begin
            if (word_num == OUT_WORD + 32'(k)) sel_out[k] = 1'b1;
        end
    end

    // STATUS layout: pending in the low N_IN bits, overrun in the next N_IN.
    logic [DATA_W-1:0] status_word;

    // Pack the sticky flags into the STATUS register image.
    always_comb begin
        status_word                  = '0;
        status_word[N_IN-1:0]        = pending;
        status_word[2*N_IN-1:N_IN]   = overrun;
    end

    // Read source mux. It sees only pre-edge state, so a same-edge write is never visible.
    logic [DATA_W-1:0] rd_next;

    // Pick the value for the selected region; unmapped words read as zero.
    always_comb begin
        rd_next = '0;
        if (sel_ram) begin
            rd_next = ram[ram_idx];
        end
        for (int k = 0; k < N_IN; k++) begin
            if (sel_in[k]) rd_next = in_reg[k];
        end
        for (int k = 0; k < N_OUT; k++) begin
            if (sel_out[k]) rd_next = out_port[k*DATA_W +: DATA_W];
        end
        if (sel_status) begin
            rd_next = status_word;
        end
    end

    // RAM write port. RAM is not reset, and I/O addresses never reach it.
    always_ff @(posedge clk) begin
        if (mem_write && sel_ram) begin
            ram[ram_idx] <= wr_data;
        end
    end

    // Registered read result and its one-cycle valid pulse. Reset drops any read in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= mem_read;
            if (mem_read) begin
                rd_data <= rd_next;
            end
        end
    end

    // Input capture plus the sticky pending/overrun flags.
    // A load beats a same-edge read clear of pending.
    // An overrun set beats a same-edge W1C clear.
    logic [N_IN-1:0] pend_rd_clr;
    logic [N_IN-1:0] ovr_w1c_clr;
    logic [N_IN-1:0] ovr_set;

    assign pend_rd_clr = mem_read  ? sel_in : '0;
    assign ovr_w1c_clr = (mem_write && sel_status) ? wr_data[2*N_IN-1:N_IN] : '0;
    assign ovr_set     = in_load & pending;

    // Input registers and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_IN; k++) begin
                in_reg[k] <= '0;
            end
            pending <= '0;
            overrun <= '0;
        end else begin
            for (int k = 0; k < N_IN; k++) begin
                if (in_load[k]) begin
                    in_reg[k] <= in_data[k*DATA_W +: DATA_W];
                end
            end
            pending <= (pending & ~pend_rd_clr) | in_load;
            overrun <= (overrun & ~ovr_w1c_clr) | ovr_set;
        end
    end

    // Output port registers with a one-cycle strobe per written port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_port   <= '0;
            out_strobe <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (mem_write && sel_out[k]) begin
                    out_port[k*DATA_W +: DATA_W] <= wr_data;
                end
            end
            out_strobe <= mem_write ? sel_out : '0;
        end
    end

endmodule

// File: doc/mmio_memory_unit.md
Name: mmio_memory_unit

Overview:
- Parametrised data-memory unit for the pipeline's MEM stage: word RAM plus a memory-mapped I/O window at the top of the address space.
- Supports N input ports with load strobes and sticky pending/overrun status, M output ports with write strobes, and a W1C status register.
- All reads, from RAM or I/O, are registered with a fixed 1-cycle latency and a valid pulse.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 10, byte-address width; addr[1:0] ignored.
- N_IN, 2, number of input ports; 2*N_IN <= DATA_W.
- N_OUT, 1, number of output ports.
- IO_BASE, 10'h3F0, first I/O byte address; word-aligned; RAM depth = IO_BASE/4 words.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- addr  in  ADDR_W  byte address.
- wr_data  in  DATA_W  store data.
- mem_write  in  1  store request.
- mem_read  in  1  load request.
- in_data  in  N_IN*DATA_W  input port k at bits [k*DATA_W +: DATA_W].
- in_load  in  N_IN  capture strobe per input port.
- rd_data  out  DATA_W  load result, held until the next accepted read.
- rd_valid  out  1  one-cycle pulse, rd_data updated.
- out_port  out  N_OUT*DATA_W  output port registers.
- out_strobe  out  N_OUT  one-cycle pulse per written output port.

Behaviour:
- Address map, word index w = addr[ADDR_W-1:2], b = IO_BASE/4:
  - w < b: RAM.
  - b <= w < b+N_IN: input port (w-b).
  - b+N_IN <= w < b+N_IN+N_OUT: output port (w-b-N_IN).
  - w = b+N_IN+N_OUT: STATUS.
  - Any other w >= b: unmapped.
- Defaults give: in0 0x3F0, in1 0x3F4, out0 0x3F8, STATUS 0x3FC.
- Reset, rst low, asynchronous:
  - in_reg, pending, overrun, out_port, rd_data, rd_valid and out_strobe all clear to 0.
  - RAM contents are not reset.
  - A read in flight is dropped; rd_valid stays 0 through and after reset until a new read.
- Reads (mem_read high at edge t):
  - After edge t, rd_data = the selected value and rd_valid = 1 for exactly one cycle.
  - RAM read is synchronous.
  - Input port read returns in_reg[k].
  - Output port read returns out_port[k].
  - STATUS read returns pending in [N_IN-1:0], overrun in [2*N_IN-1:N_IN], 0 elsewhere.
  - Unmapped addresses read 0.
- Writes (mem_write high at edge t):
  - RAM address: word written.
  - Output port k: out_port[k] <= wr_data at t, and out_strobe[k] = 1 for the cycle after t.
  - STATUS: W1C; overrun[k] cleared where wr_data[N_IN+k] = 1; pending bits unaffected.
  - Input port or unmapped address: ignored, no state change.
  - I/O addresses never write RAM.
- Simultaneous mem_read and mem_write, same address: read returns the pre-write value; the write takes effect. This applies to RAM, out_port and STATUS.
- Input capture (in_load[k] high at edge):
  - in_reg[k] <= in_data slice and pending[k] <= 1.
  - If pending[k] was already 1, overrun[k] <= 1 (sticky).
- Reading input port k clears pending[k] at the read edge.
- Same-edge load and read of port k:
  - Read returns the old in_reg[k].
  - New data is captured and pending[k] stays 1.
  - overrun[k] is set only if pending[k] was 1 before the edge.
- Same-edge load setting overrun[k] and STATUS W1C clearing it: set wins.
- Multiple in_load bits may be high in the same cycle; ports are independent.
- Latency: loads 1 cycle; stores and strobes visible 1 cycle after the edge.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x004 and read 0x004 -> rd_valid pulses 1 cycle after the read edge, rd_data = 0xDEADBEEF.
- in_load[1] with in_data slice 0x1234 -> STATUS reads 0x2; read 0x3F4 returns 0x1234; STATUS then reads 0x0.
- Two in_load[0] pulses (0xA then 0xB) without a read -> STATUS = 0x5 and 0x3F0 reads 0xB. Write 0x4 to 0x3FC -> STATUS = 0x1.
- Write 0x55 to 0x3F8 -> out_port = 0x55 and out_strobe pulses exactly once. A RAM read at word 0x3F8/4 path (addr 0x3F8) returns 0x55, and RAM is unchanged.
- Same-edge in_load[0] (0x77) and read 0x3F0, with in_reg = 0x66 and pending = 1 -> rd_data = 0x66, in_reg = 0x77, pending[0] = 1, overrun[0] = 1.
- Drop rst low the cycle after a read request -> rd_valid never pulses; out_port = 0, STATUS = 0; RAM word 0x004 still reads 0xDEADBEEF after release.
